cgb_palette_regs: RTL and testbench
===================================

CGB_PALETTE_REGS -- requirements
Module: cgb_palette_regs

Interface
REQ-001 SHALL have parameter INIT_EN, default 1, meaning the post-reset palette fill sequencer is enabled.
REQ-002 SHALL have parameter INIT_DATA, default 8'hFF, meaning the byte written to every palette location during the fill (white, 15'h7FFF).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_en  input  1  clock enable; all state advances only on clk edges with cpu_en=1.
REQ-006 SHALL have port reg_sel  input  2  register select: 0=BCPS (FF68), 1=BCPD (FF69), 2=OCPS (FF6A), 3=OCPD (FF6B).
REQ-007 SHALL have ports rd, wr  input  1 each  CPU read and write strobes for the selected register.
REQ-008 SHALL have port wdata  input  8  CPU write data.
REQ-009 SHALL have port rdata  output  8  CPU read data, combinational.
REQ-010 SHALL have port ppu_lock  input  1  PPU is fetching palettes (mode 3 with LCD on); data-port access is blocked.
REQ-011 SHALL have ports bg_palette_addr, sp_palette_addr  output  6 each  palette RAM byte addresses (shared read/write).
REQ-012 SHALL have ports bg_palette_rdata, sp_palette_rdata  input  8 each  palette RAM read data.
REQ-013 SHALL have ports pal_wdata  output  8, pal_write  output  2  palette RAM write data and strobes (bit0=BG, bit1=OBJ).
REQ-014 SHALL have port init_busy  output  1  fill sequencer active.

Function
REQ-015 SHALL hold per-side state: 6-bit index and 1-bit auto-increment flag, for BG and OBJ.
REQ-016 SHALL have two states: INIT (fill) and IDLE; leave reset in INIT when INIT_EN=1, else IDLE.
REQ-017 SHALL, in INIT, use a 7-bit counter cnt; per enabled cycle drive addr=cnt[5:0] on the selected side, pal_write=cnt[6]?2'b10:2'b01, pal_wdata=INIT_DATA, then cnt+1.
REQ-018 SHALL move INIT->IDLE on the enabled edge where cnt=127 (exactly 128 writes); init_busy=1 only in INIT.
REQ-019 SHALL, in INIT, ignore CPU writes (no register change) and return rdata=8'hFF for all reg_sel.
REQ-020 SHALL, in IDLE, drive bg/sp_palette_addr from the BG/OBJ index; pal_wdata=wdata.
REQ-021 SHALL, on a write to BCPS/OCPS, load index<=wdata[5:0] and auto-inc<=wdata[7] at the enabled edge; wdata[6] is ignored.
REQ-022 SHALL read BCPS/OCPS as {auto_inc, 1'b1, index}.
REQ-023 SHALL, on a write to BCPD/OCPD with ppu_lock=0, assert the matching pal_write bit combinationally in that cycle (only when cpu_en=1).
REQ-024 SHALL, on any write to BCPD/OCPD (locked or not), increment index modulo 64 (63->0) at that edge when auto-inc=1; pal_write stays 0 while locked.
REQ-025 SHALL read BCPD/OCPD as bg/sp_palette_rdata when ppu_lock=0, else 8'hFF; reads have no side effects (no increment).
REQ-026 SHALL, if rd and wr are both asserted, perform the write and still return rdata from pre-edge state.
REQ-027 SHALL never assert both pal_write bits in one cycle.

Reset
REQ-028 SHALL on reset_n=0 immediately set both indices=0, both auto-inc=0, cnt=0, state=INIT (INIT_EN=1) or IDLE.
REQ-029 SHALL during reset hold pal_write=0; reset mid-INIT restarts the fill at cnt=0.

Structure
REQ-030 SHALL place the reg_sel encodings and the INIT/IDLE state enum in the shared PPU package.
REQ-031 SHALL be a single module with no sub-modules; it connects directly to cgb_palettes write/address ports.

Verification
REQ-032 Reset, INIT_EN=1, cpu_en=1 -> 128 cycles of writes, BG 0..63 then OBJ 0..63 with 8'hFF; init_busy falls after cycle 128; rdata=FF throughout.
REQ-033 Write BCPS=8'hBE, then BCPD 0x12,0x34 -> BG[62]=12, BG[63]=34, index wraps to 0; BCPS reads 8'hC0.
REQ-034 OCPS=8'h05 (no auto-inc), write OCPD 0xAA twice -> OBJ[5]=AA, index stays 5, OCPS reads 8'h45.
REQ-035 BCPS=8'h80, ppu_lock=1, write BCPD 0x55 -> no pal_write, index 0->1; BCPD read returns FF; after lock drops reads BG[1].
REQ-036 cpu_en=0 with wr to BCPD -> no pal_write, index unchanged; reset_n pulsed at cnt=40 -> fill restarts at 0.

Source files
------------

// File: rtl/cgb_palette_regs_pkg.sv
// rtl/cgb_palette_regs_pkg.sv - shared PPU palette register encodings and sequencer states
package cgb_palette_regs_pkg;

  typedef enum logic [1:0] {
    SEL_BCPS = 2'd0,
    SEL_BCPD = 2'd1,
    SEL_OCPS = 2'd2,
    SEL_OCPD = 2'd3
  } reg_sel_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } pal_state_e;

  localparam logic [6:0] FILL_LAST = 7'd127;

endpackage

// File: rtl/cgb_palette_regs.sv
// rtl/cgb_palette_regs.sv - CGB BCPS/BCPD/OCPS/OCPD palette index/data ports with post-reset fill
module cgb_palette_regs
  import cgb_palette_regs_pkg::*;
#(
  parameter bit         INIT_EN   = 1'b1,
  parameter logic [7:0] INIT_DATA = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_en,
  input  logic [1:0] reg_sel,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       ppu_lock,
  output logic [5:0] bg_palette_addr,
  output logic [5:0] sp_palette_addr,
  input  logic [7:0] bg_palette_rdata,
  input  logic [7:0] sp_palette_rdata,
  output logic [7:0] pal_wdata,
  output logic [1:0] pal_write,
  output logic       init_busy
);

  pal_state_e state_q, state_d;
  logic [6:0] cnt_q;
  logic [5:0] bg_idx_q, sp_idx_q;
  logic       bg_ai_q, sp_ai_q;
  reg_sel_e   sel;

  assign sel = reg_sel_e'(reg_sel);

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && cpu_en && cnt_q == FILL_LAST) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt_q    <= '0;
      bg_idx_q <= '0;
      sp_idx_q <= '0;
      bg_ai_q  <= 1'b0;
      sp_ai_q  <= 1'b0;
    end else if (cpu_en) begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        cnt_q <= cnt_q + 7'd1;
      end else if (wr) begin
        // Data-port writes advance the index even when the PPU lock drops the RAM write.
        case (sel)
          SEL_BCPS: begin
            bg_idx_q <= wdata[5:0];
            bg_ai_q  <= wdata[7];
          end
          SEL_BCPD: if (bg_ai_q) bg_idx_q <= bg_idx_q + 6'd1;
          SEL_OCPS: begin
            sp_idx_q <= wdata[5:0];
            sp_ai_q  <= wdata[7];
          end
          SEL_OCPD: if (sp_ai_q) sp_idx_q <= sp_idx_q + 6'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    init_busy       = (state_q == ST_INIT);
    bg_palette_addr = bg_idx_q;
    sp_palette_addr = sp_idx_q;
    pal_wdata       = wdata;
    pal_write       = 2'b00;
    rdata           = 8'hFF;
    if (state_q == ST_INIT) begin
      bg_palette_addr = cnt_q[5:0];
      sp_palette_addr = cnt_q[5:0];
      pal_wdata       = INIT_DATA;
      if (cpu_en && reset_n) pal_write = cnt_q[6] ? 2'b10 : 2'b01;
    end else begin
      if (wr && cpu_en && !ppu_lock) begin
        if (sel == SEL_BCPD)      pal_write = 2'b01;
        else if (sel == SEL_OCPD) pal_write = 2'b10;
      end
      // An unselected read floats the bus high like an open data bus.
      if (rd) begin
        case (sel)
          SEL_BCPS: rdata = {bg_ai_q, 1'b1, bg_idx_q};
          SEL_BCPD: rdata = ppu_lock ? 8'hFF : bg_palette_rdata;
          SEL_OCPS: rdata = {sp_ai_q, 1'b1, sp_idx_q};
          SEL_OCPD: rdata = ppu_lock ? 8'hFF : sp_palette_rdata;
          default:  rdata = 8'hFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cgb_palette_regs.sv
// tb/tb_cgb_palette_regs.sv - directed vector bench for cgb_palette_regs
module tb_cgb_palette_regs;
  logic       clk;
  logic       reset_n;
  logic       cpu_en;
  logic [1:0] reg_sel;
  logic       rd;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ppu_lock;
  logic [5:0] bg_palette_addr;
  logic [5:0] sp_palette_addr;
  logic [7:0] bg_palette_rdata;
  logic [7:0] sp_palette_rdata;
  logic [7:0] pal_wdata;
  logic [1:0] pal_write;
  logic       init_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] bg_ram [64];
  logic [7:0] sp_ram [64];

  typedef struct {
    logic [1:0] sel;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic       lock;
    logic       en;
    logic [7:0] exp_rdata;
    logic [1:0] exp_pw;
    logic [5:0] exp_bga;
    logic [5:0] exp_spa;
  } vec_t;

  vec_t vecs[$];

  cgb_palette_regs dut (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .reg_sel(reg_sel),
    .rd(rd), .wr(wr), .wdata(wdata), .rdata(rdata), .ppu_lock(ppu_lock),
    .bg_palette_addr(bg_palette_addr), .sp_palette_addr(sp_palette_addr),
    .bg_palette_rdata(bg_palette_rdata), .sp_palette_rdata(sp_palette_rdata),
    .pal_wdata(pal_wdata), .pal_write(pal_write), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bg_palette_rdata = bg_ram[bg_palette_addr];
  assign sp_palette_rdata = sp_ram[sp_palette_addr];

  always @(posedge clk) begin
    if (pal_write[0]) bg_ram[bg_palette_addr] <= pal_wdata;
    if (pal_write[1]) sp_ram[sp_palette_addr] <= pal_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] s, input logic r, input logic w, input logic [7:0] d,
                     input logic l, input logic e, input logic [7:0] er, input logic [1:0] epw,
                     input logic [5:0] ea, input logic [5:0] es);
    vec_t v;
    v.sel = s; v.rd = r; v.wr = w; v.wdata = d; v.lock = l; v.en = e;
    v.exp_rdata = er; v.exp_pw = epw; v.exp_bga = ea; v.exp_spa = es;
    vecs.push_back(v);
  endtask

  task automatic fill_cycles(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      wr = 1'b0;
      if (full && i == 10) begin wr = 1'b1; reg_sel = 2'd0; wdata = 8'hBF; end
      if (full && i == 11) begin wr = 1'b1; reg_sel = 2'd1; wdata = 8'h00; end
      if (full && i == 12) reg_sel = 2'd0;
      #1;
      chk($sformatf("fill_busy[%0d]", i), init_busy, 1'b1);
      chk($sformatf("fill_pw[%0d]", i), pal_write, (i < 64) ? 2'b01 : 2'b10);
      chk($sformatf("fill_addr[%0d]", i), (i < 64) ? bg_palette_addr : sp_palette_addr, i % 64);
      chk($sformatf("fill_wdata[%0d]", i), pal_wdata, 8'hFF);
      chk($sformatf("fill_rdata[%0d]", i), rdata, 8'hFF);
      @(negedge clk);
    end
    wr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin bg_ram[i] = 8'h00; sp_ram[i] = 8'h00; end
    reset_n = 1'b0; cpu_en = 1'b1; reg_sel = 2'd0; rd = 1'b1; wr = 1'b0;
    wdata = 8'h00; ppu_lock = 1'b0;
    #1;
    chk("reset_pw", pal_write, 2'b00);
    chk("reset_busy", init_busy, 1'b1);
    chk("reset_rdata", rdata, 8'hFF);

    @(negedge clk);
    reset_n = 1'b1;
    fill_cycles(40, 1'b0);
    #1;
    chk("mid_fill_addr40", bg_palette_addr, 6'd40);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_pw", pal_write, 2'b00);
    chk("mid_reset_addr", bg_palette_addr, 6'd0);
    @(negedge clk);
    reset_n = 1'b1;
    fill_cycles(128, 1'b1);
    #1;
    chk("fill_done_busy", init_busy, 1'b0);
    chk("fill_done_pw", pal_write, 2'b00);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("bg_ram_fill[%0d]", i), bg_ram[i], 8'hFF);
      chk($sformatf("sp_ram_fill[%0d]", i), sp_ram[i], 8'hFF);
    end

    //  sel rd wr wdata  lk en  rdata  pw     bga  spa
    add(2'd0, 1, 0, 8'h00, 0, 1, 8'h40, 2'b00, 0,  0);
    add(2'd0, 1, 1, 8'hBE, 0, 1, 8'h40, 2'b00, 0,  0);
    add(2'd0, 1, 0, 8'h00, 0, 1, 8'hFE, 2'b00, 62, 0);
    add(2'd1, 1, 1, 8'h12, 0, 1, 8'hFF, 2'b01, 62, 0);
    add(2'd1, 1, 1, 8'h34, 0, 1, 8'hFF, 2'b01, 63, 0);
    add(2'd0, 1, 0, 8'h00, 0, 1, 8'hC0, 2'b00, 0,  0);
    add(2'd0, 1, 1, 8'h3E, 0, 1, 8'hC0, 2'b00, 0,  0);
    add(2'd1, 1, 0, 8'h00, 0, 1, 8'h12, 2'b00, 62, 0);
    add(2'd0, 1, 1, 8'h3F, 0, 1, 8'h7E, 2'b00, 62, 0);
    add(2'd1, 1, 0, 8'h00, 0, 1, 8'h34, 2'b00, 63, 0);
    add(2'd2, 1, 1, 8'h05, 0, 1, 8'h40, 2'b00, 63, 0);
    add(2'd3, 1, 1, 8'hAA, 0, 1, 8'hFF, 2'b10, 63, 5);
    add(2'd3, 1, 1, 8'hAA, 0, 1, 8'hAA, 2'b10, 63, 5);
    add(2'd2, 1, 0, 8'h00, 0, 1, 8'h45, 2'b00, 63, 5);
    add(2'd3, 1, 0, 8'h00, 0, 1, 8'hAA, 2'b00, 63, 5);
    add(2'd0, 1, 1, 8'h01, 0, 1, 8'h7F, 2'b00, 63, 5);
    add(2'd1, 1, 1, 8'h5A, 0, 1, 8'hFF, 2'b01, 1,  5);
    add(2'd0, 1, 1, 8'h80, 0, 1, 8'h41, 2'b00, 1,  5);
    add(2'd1, 1, 1, 8'h55, 1, 1, 8'hFF, 2'b00, 0,  5);
    add(2'd1, 1, 0, 8'h00, 1, 1, 8'hFF, 2'b00, 1,  5);
    add(2'd1, 1, 0, 8'h00, 1, 1, 8'hFF, 2'b00, 1,  5);
    add(2'd1, 1, 0, 8'h00, 0, 1, 8'h5A, 2'b00, 1,  5);
    add(2'd0, 1, 0, 8'h00, 0, 1, 8'hC1, 2'b00, 1,  5);
    add(2'd1, 1, 1, 8'h77, 0, 0, 8'h5A, 2'b00, 1,  5);
    add(2'd0, 1, 0, 8'h00, 0, 1, 8'hC1, 2'b00, 1,  5);
    add(2'd1, 1, 0, 8'h00, 0, 1, 8'h5A, 2'b00, 1,  5);
    add(2'd0, 1, 1, 8'h3F, 0, 0, 8'hC1, 2'b00, 1,  5);
    add(2'd0, 1, 0, 8'h00, 0, 1, 8'hC1, 2'b00, 1,  5);
    add(2'd0, 0, 0, 8'h00, 0, 1, 8'hFF, 2'b00, 1,  5);
    add(2'd2, 1, 1, 8'hBF, 0, 1, 8'h45, 2'b00, 1,  5);
    add(2'd3, 1, 1, 8'h11, 0, 1, 8'hFF, 2'b10, 1,  63);
    add(2'd2, 1, 0, 8'h00, 0, 1, 8'hC0, 2'b00, 1,  0);

    foreach (vecs[k]) begin
      reg_sel = vecs[k].sel; rd = vecs[k].rd; wr = vecs[k].wr; wdata = vecs[k].wdata;
      ppu_lock = vecs[k].lock; cpu_en = vecs[k].en;
      #1;
      chk($sformatf("vec%0d_rdata", k), rdata, vecs[k].exp_rdata);
      chk($sformatf("vec%0d_pal_write", k), pal_write, vecs[k].exp_pw);
      chk($sformatf("vec%0d_bg_addr", k), bg_palette_addr, vecs[k].exp_bga);
      chk($sformatf("vec%0d_sp_addr", k), sp_palette_addr, vecs[k].exp_spa);
      if (vecs[k].exp_pw != 2'b00) chk($sformatf("vec%0d_pal_wdata", k), pal_wdata, vecs[k].wdata);
      @(negedge clk);
    end
    wr = 1'b0; cpu_en = 1'b1; ppu_lock = 1'b0;
    #1;
    chk("ram_bg62", bg_ram[62], 8'h12);
    chk("ram_bg63", bg_ram[63], 8'h34);
    chk("ram_bg0_untouched", bg_ram[0], 8'hFF);
    chk("ram_bg1", bg_ram[1], 8'h5A);
    chk("ram_sp5", sp_ram[5], 8'hAA);
    chk("ram_sp63", sp_ram[63], 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
